// File: rtl/core_mem_arb_pkg.sv
// Shared types and constants for the core memory arbiter slice.
package core_mem_arb_pkg;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_sel_t;

  localparam int unsigned STARVE_CNT_W     = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Fetch, data and shared memory bus signals; slave is the arbiter's view, master the environment's.
interface core_mem_arbiter_if #(
  parameter int unsigned MEM_ADDR_W = 64,
  parameter int unsigned MEM_DATA_W = 64,
  parameter int unsigned MEM_STRB_W = 8
);
  logic                  i_req;
  logic                  i_gnt;
  logic [MEM_ADDR_W-1:0] i_addr;
  logic                  i_wen;
  logic [MEM_STRB_W-1:0] i_strb;
  logic [MEM_DATA_W-1:0] i_wdata;
  logic [MEM_DATA_W-1:0] i_rdata;
  logic                  i_err;

  logic                  d_req;
  logic                  d_gnt;
  logic [MEM_ADDR_W-1:0] d_addr;
  logic                  d_wen;
  logic [MEM_STRB_W-1:0] d_strb;
  logic [MEM_DATA_W-1:0] d_wdata;
  logic [MEM_DATA_W-1:0] d_rdata;
  logic                  d_err;

  logic                  m_req;
  logic                  m_gnt;
  logic [MEM_ADDR_W-1:0] m_addr;
  logic                  m_wen;
  logic [MEM_STRB_W-1:0] m_strb;
  logic [MEM_DATA_W-1:0] m_wdata;
  logic [MEM_DATA_W-1:0] m_rdata;
  logic                  m_err;

  modport slave (
    input  i_req, i_addr, i_wen, i_strb, i_wdata,
    output i_gnt, i_rdata, i_err,
    input  d_req, d_addr, d_wen, d_strb, d_wdata,
    output d_gnt, d_rdata, d_err,
    output m_req, m_addr, m_wen, m_strb, m_wdata,
    input  m_gnt, m_rdata, m_err
  );

  modport master (
    output i_req, i_addr, i_wen, i_strb, i_wdata,
    input  i_gnt, i_rdata, i_err,
    output d_req, d_addr, d_wen, d_strb, d_wdata,
    input  d_gnt, d_rdata, d_err,
    input  m_req, m_addr, m_wen, m_strb, m_wdata,
    output m_gnt, m_rdata, m_err
  );
endinterface

// File: rtl/core_mem_arb_starve.sv
// Counts consecutive denied fetch cycles and raises fetch priority once the limit is reached.
module core_mem_arb_starve
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  input  logic                    i_req,
  input  logic                    i_gnt,
  input  logic                    hold_v,
  output logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    fetch_pri
);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // A held owner must finish first, so priority waits for the hold to drop.
  assign fetch_pri = (starve_cnt == LIMIT) && !hold_v;

endmodule

// File: rtl/core_mem_arbiter.sv
// 2:1 arbiter sharing one memory bus between fetch and load/store; data wins unless fetch starves.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W   = 64,
  parameter int unsigned MEM_DATA_W   = 64,
  parameter int unsigned MEM_STRB_W   = 8,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  core_mem_arbiter_if.slave  bus
);
  arb_sel_t                sel;
  arb_sel_t                hold_sel;
  arb_sel_t                rsp_sel;
  logic                    hold_v;
  logic                    rsp_v;
  logic                    fetch_pri;
  logic                    m_req_int;
  logic                    accept;
  logic                    i_gnt_int;
  logic                    owner_req;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  logic [MEM_ADDR_W-1:0]   mux_addr;
  logic                    mux_wen;
  logic [MEM_STRB_W-1:0]   mux_strb;
  logic [MEM_DATA_W-1:0]   mux_wdata;

  always_comb begin
    sel = ARB_I;
    if (hold_v) begin
      sel = hold_sel;
    end else if (bus.i_req && (!bus.d_req || fetch_pri)) begin
      sel = ARB_I;
    end else if (bus.d_req) begin
      sel = ARB_D;
    end
  end

  always_comb begin
    mux_addr  = bus.i_addr;
    mux_wen   = bus.i_wen;
    mux_strb  = bus.i_strb;
    mux_wdata = bus.i_wdata;
    if (sel == ARB_D) begin
      mux_addr  = bus.d_addr;
      mux_wen   = bus.d_wen;
      mux_strb  = bus.d_strb;
      mux_wdata = bus.d_wdata;
    end
  end

  assign m_req_int   = (bus.i_req || bus.d_req) && g_resetn;
  assign accept      = m_req_int && bus.m_gnt;
  assign i_gnt_int   = accept && (sel == ARB_I);

  assign bus.m_req   = m_req_int;
  assign bus.m_addr  = mux_addr;
  assign bus.m_wen   = mux_wen;
  assign bus.m_strb  = mux_strb;
  assign bus.m_wdata = mux_wdata;
  assign bus.i_gnt   = i_gnt_int;
  assign bus.d_gnt   = accept && (sel == ARB_D);

  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  assign bus.i_err   = g_resetn && bus.m_err && rsp_v && (rsp_sel == ARB_I);
  assign bus.d_err   = g_resetn && bus.m_err && rsp_v && (rsp_sel == ARB_D);

  core_mem_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .i_req      (bus.i_req),
    .i_gnt      (i_gnt_int),
    .hold_v     (hold_v),
    .starve_cnt (starve_cnt),
    .fetch_pri  (fetch_pri)
  );

  // Any non-stalled cycle (accepted or idle) drops the hold, so arbitration restarts fresh.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      hold_v   <= 1'b0;
      hold_sel <= ARB_I;
      rsp_v    <= 1'b0;
      rsp_sel  <= ARB_I;
    end else begin
      hold_v   <= m_req_int && !bus.m_gnt;
      if (m_req_int && !bus.m_gnt) begin
        hold_sel <= sel;
      end
      rsp_v    <= accept;
      rsp_sel  <= sel;
    end
  end

  assign owner_req = (hold_sel == ARB_I) ? bus.i_req : bus.d_req;

  a_gnt_onehot: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(bus.i_gnt && bus.d_gnt));

  a_hold_stable: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (m_req_int && !bus.m_gnt) |=>
      (owner_req && $stable(mux_addr) && $stable(mux_wen) &&
       $stable(mux_strb) && $stable(mux_wdata)));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter.
module tb_core_mem_arbiter;
  import core_mem_arb_pkg::*;

  logic g_clk = 1'b0;
  logic g_resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter_if #(
    .MEM_ADDR_W (64),
    .MEM_DATA_W (64),
    .MEM_STRB_W (8)
  ) bus ();

  core_mem_arbiter #(
    .MEM_ADDR_W   (64),
    .MEM_DATA_W   (64),
    .MEM_STRB_W   (8),
    .STARVE_LIMIT (4)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic exp_m, input logic exp_i, input logic exp_d);
    chk({tag, "_m_req"}, 64'(bus.m_req), 64'(exp_m));
    chk({tag, "_i_gnt"}, 64'(bus.i_gnt), 64'(exp_i));
    chk({tag, "_d_gnt"}, 64'(bus.d_gnt), 64'(exp_d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    g_resetn  = 1'b0;
    bus.i_req = 1'b1;  bus.i_addr = 64'h0; bus.i_wen = 1'b0; bus.i_strb = 8'hFF; bus.i_wdata = 64'h0;
    bus.d_req = 1'b1;  bus.d_addr = 64'h0; bus.d_wen = 1'b0; bus.d_strb = 8'hFF; bus.d_wdata = 64'h0;
    bus.m_gnt = 1'b1;  bus.m_rdata = 64'h0; bus.m_err = 1'b1;

    // Reset: outputs forced low, state cleared.
    cyc();
    chk_gnt("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_i_err", 64'(bus.i_err), 64'(0));
    chk("rst_d_err", 64'(bus.d_err), 64'(0));
    chk("rst_cnt", 64'(dut.starve_cnt), 64'(0));
    chk("rst_hold", 64'(dut.hold_v), 64'(0));

    g_resetn  = 1'b1;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_err = 1'b0;
    #1;
    chk_gnt("idle", 1'b0, 1'b0, 1'b0);
    cyc();

    // Lone fetch requester.
    bus.i_req  = 1'b1;
    bus.i_addr = 64'h8000_0000;
    bus.d_addr = 64'h0000_1000;
    #1;
    chk("lone_m_addr", bus.m_addr, 64'h8000_0000);
    chk_gnt("lone", 1'b1, 1'b1, 1'b0);
    cyc();
    bus.i_req   = 1'b0;
    bus.m_rdata = 64'hDEAD;
    #1;
    chk("lone_i_rdata", bus.i_rdata, 64'hDEAD);
    chk("lone_i_err", 64'(bus.i_err), 64'(0));
    chk("lone_d_err", 64'(bus.d_err), 64'(0));
    cyc();

    // Contention: data wins four times, then starved fetch gets one grant.
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.i_addr = 64'hA000;
    bus.d_addr = 64'hB000;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 4) begin
        chk("cont_cnt4", 64'(dut.starve_cnt), 64'(4));
        chk_gnt("cont_i", 1'b1, 1'b1, 1'b0);
        chk("cont_addr_i", bus.m_addr, 64'hA000);
      end else begin
        chk_gnt("cont_d", 1'b1, 1'b0, 1'b1);
        chk("cont_addr_d", bus.m_addr, 64'hB000);
      end
      cyc();
    end

    // Response of the last data grant carries an error only to data.
    bus.m_err   = 1'b1;
    bus.m_rdata = 64'h1234;
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_addr  = 64'h2000;
    bus.m_gnt   = 1'b0;
    #1;
    chk("errd_d_err", 64'(bus.d_err), 64'(1));
    chk("errd_i_err", 64'(bus.i_err), 64'(0));
    chk("errd_d_rdata", bus.d_rdata, 64'h1234);

    // Stall hold: data keeps ownership while fetch arrives.
    chk("stall0_addr", bus.m_addr, 64'h2000);
    chk_gnt("stall0", 1'b1, 1'b0, 1'b0);
    cyc();
    bus.m_err  = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 64'h3000;
    for (int s = 1; s < 3; s++) begin
      #1;
      chk("stall_hold", 64'(dut.hold_v), 64'(1));
      chk("stall_addr", bus.m_addr, 64'h2000);
      chk_gnt("stall", 1'b1, 1'b0, 1'b0);
      cyc();
    end
    bus.m_gnt = 1'b1;
    #1;
    chk("stall_rel_addr", bus.m_addr, 64'h2000);
    chk_gnt("stall_rel", 1'b1, 1'b0, 1'b1);
    cyc();
    bus.d_req = 1'b0;
    #1;
    chk("post_addr", bus.m_addr, 64'h3000);
    chk_gnt("post", 1'b1, 1'b1, 1'b0);
    cyc();

    // Response of the fetch grant carries an error only to fetch.
    bus.i_req = 1'b0;
    bus.m_err = 1'b1;
    #1;
    chk("erri_i_err", 64'(bus.i_err), 64'(1));
    chk("erri_d_err", 64'(bus.d_err), 64'(0));
    cyc();

    // Reset mid-operation with a held request and a partly counted starvation.
    bus.m_err = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    bus.m_gnt = 1'b1;
    cyc();
    cyc();
    bus.m_gnt = 1'b0;
    cyc();
    chk("mid_hold", 64'(dut.hold_v), 64'(1));
    chk("mid_cnt", 64'(dut.starve_cnt), 64'(3));
    g_resetn  = 1'b0;
    bus.m_gnt = 1'b1;
    #1;
    chk_gnt("mid_rst", 1'b0, 1'b0, 1'b0);
    cyc();
    g_resetn = 1'b1;
    #1;
    chk("rel_hold", 64'(dut.hold_v), 64'(0));
    chk_gnt("rel", 1'b1, 1'b0, 1'b1);
    cyc();
    chk("rel_cnt", 64'(dut.starve_cnt), 64'(1));

    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the load/store requester.
- Places a 2:1 arbiter between the two core memory request ports and the single external memory bus.
- Policy: data side wins by default. A starvation counter guarantees fetch progress. A request stalled by a deasserted downstream grant keeps ownership until it is accepted.
- Responses return exactly one cycle after acceptance and go back only to the requester that was granted.

Parameters:
- MEM_ADDR_W, 64, address width.
- MEM_DATA_W, 64, data width.
- MEM_STRB_W, 8, byte-strobe width.
- STARVE_LIMIT, 4, consecutive cycles fetch may be requesting-and-denied before it gains priority. Range 1..15.

Ports:
- g_clk, in, 1, global clock.
- g_resetn, in, 1, global reset. Synchronous, active-low.
- i_req, in, 1, fetch request.
- i_gnt, out, 1, fetch request accepted.
- i_addr, in, MEM_ADDR_W, fetch address.
- i_wen, in, 1, fetch write enable (always 0 in use; forwarded anyway).
- i_strb, in, MEM_STRB_W, fetch strobes.
- i_wdata, in, MEM_DATA_W, fetch write data.
- i_rdata, out, MEM_DATA_W, fetch read data.
- i_err, out, 1, fetch response error.
- d_req / d_gnt / d_addr / d_wen / d_strb / d_wdata / d_rdata / d_err: same directions and widths as the i_* ports, for the data requester.
- m_req, out, 1, shared bus request.
- m_gnt, in, 1, shared bus grant.
- m_addr, out, MEM_ADDR_W, shared bus address.
- m_wen, out, 1, shared bus write enable.
- m_strb, out, MEM_STRB_W, shared bus strobes.
- m_wdata, out, MEM_DATA_W, shared bus write data.
- m_rdata, in, MEM_DATA_W, shared bus read data.
- m_err, in, 1, shared bus response error.

Behaviour:
- Bus protocol, all ports:
  - Transfer accepted in the cycle req && gnt.
  - rdata/err valid exactly the cycle after acceptance.
  - A requester holds req, addr, wen, strb and wdata stable until gnt.
  - Downstream may accept back-to-back, one request per cycle.
- Select logic (combinational):
  - sel = D if d_req and no fetch priority; I if i_req and (not d_req or fetch priority).
  - A held owner overrides the above.
- m_req, m_addr, m_wen, m_strb, m_wdata:
  - m_req = i_req || d_req.
  - All other m_* outputs are muxed from sel.
- Grants: i_gnt = m_gnt && sel==I; d_gnt = m_gnt && sel==D. Never both in one cycle.
- Hold register (hold_v, hold_sel):
  - Set when m_req && !m_gnt, capturing sel.
  - Cleared on m_req && m_gnt.
  - While hold_v, sel = hold_sel, even if the other requester has higher priority.
- Starvation counter (starve_cnt, 4 bits):
  - Increments when i_req && !i_gnt.
  - Saturates at STARVE_LIMIT.
  - Clears on i_gnt or when !i_req.
- Fetch priority: active when starve_cnt == STARVE_LIMIT and !hold_v.
- Response routing:
  - rsp_v <= m_req && m_gnt; rsp_sel <= sel.
  - i_rdata and d_rdata both carry m_rdata (broadcast).
  - i_err = m_err && rsp_v && rsp_sel==I; d_err likewise for D.
  - Error is never routed to the non-owner.
- Latency: zero-cycle combinational forward path; one registered cycle on the response.
- Reset, while !g_resetn:
  - hold_v=0, rsp_v=0, rsp_sel=I, starve_cnt=0.
  - m_req, i_gnt and d_gnt forced 0 combinationally; i_err and d_err are 0.
- Simultaneous events:
  - Grant and new request in the same cycle: the next cycle re-arbitrates from scratch.
  - Requester drops req while held (a protocol violation): hold clears the next cycle when m_req falls. Assertion flags it.
- Assertions:
  - i_gnt and d_gnt never both high.
  - Held request fields stay stable until gnt.

Decomposition:
- core_mem_arb_pkg holds:
  - typedef arb_sel_t (ARB_I=0, ARB_D=1);
  - STARVE_CNT_W=4;
  - the default STARVE_LIMIT.
- One natural sub-module: core_mem_arb_starve, containing the starvation counter and the priority flag.
- The mux and the hold/response registers stay inline.

Test Plan:
- Lone requester: i_req=1, d_req=0, m_gnt=1, i_addr=0x80000000 -> m_addr=0x80000000, i_gnt=1. Next cycle m_rdata=0xDEAD drives i_rdata=0xDEAD; i_err=0 and d_err=0 with m_err=0.
- Contention: both req=1, m_gnt=1 -> d_gnt=1 in cycles 0-3. starve_cnt reaches 4, so cycle 4 gives i_gnt=1, d_gnt=0; cycle 5 gives d_gnt=1 again.
- Stall hold: d_req=1, m_gnt=0 for 3 cycles, i_req raised in cycle 1 -> sel stays D and m_addr stays d_addr. When m_gnt=1, d_gnt=1 and i_gnt=0.
- Error routing: grant I, next cycle m_err=1 -> i_err=1, d_err=0. Repeat on the D side -> d_err=1, i_err=0.
- Reset mid-operation: hold_v=1 and starve_cnt=3, then g_resetn=0 for 1 cycle -> m_req=0, i_gnt=0, d_gnt=0 during reset. After release, the first contended cycle grants D and starve_cnt=1.
